// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM states and latched-request payload for the data cache.
package dcache_pkg;

    localparam int unsigned DC_SETS  = 64;
    localparam int unsigned DC_WORDS = 8;
    localparam int unsigned DC_OFF_W = $clog2(DC_WORDS);
    localparam int unsigned DC_IDX_W = $clog2(DC_SETS);
    localparam int unsigned DC_TAG_W = 64 - 3 - DC_OFF_W - DC_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL,
        ST_WTHRU
    } state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic        wren;
        logic [63:0] wdata;
    } req_t;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped valid/tag/data storage with combinational read and synchronous writes.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned SETS  = DC_SETS,
    parameter int unsigned WORDS = DC_WORDS,
    parameter int unsigned TAG_W = DC_TAG_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(SETS)-1:0]    rd_index,
    input  logic [$clog2(WORDS)-1:0]   rd_offset,
    output logic                       rd_valid_c,
    output logic [TAG_W-1:0]           rd_tag_c,
    output logic [63:0]                rd_data_c,
    input  logic                       wr_en,
    input  logic [$clog2(SETS)-1:0]    wr_index,
    input  logic [$clog2(WORDS)-1:0]   wr_offset,
    input  logic [63:0]                wr_data,
    input  logic                       fill_en,
    input  logic [TAG_W-1:0]           fill_tag
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [63:0]      data_q [SETS*WORDS];

    // Line valid bits: cleared on reset, set when a refill completes
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag written alongside the valid bit at refill completion
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[wr_index] <= fill_tag;
        end
    end

    // Single word write port shared by refill beats and store hits
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid_c = valid_q[rd_index];
    assign rd_tag_c   = tag_q[rd_index];
    assign rd_data_c  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through data cache responder with line refill.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned SETS  = DC_SETS,
    parameter int unsigned WORDS = DC_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcache_en,
    input  logic        dcache_wren,
    input  logic [63:0] dcache_addr,
    input  logic [63:0] dcache_wdata,
    output logic [63:0] dcache_rdata,
    output logic        dcache_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int unsigned OFF_W    = $clog2(WORDS);
    localparam int unsigned IDX_W    = $clog2(SETS);
    localparam int unsigned LINE_LSB = 3 + OFF_W;
    localparam int unsigned TAG_LSB  = LINE_LSB + IDX_W;
    localparam int unsigned TAG_W    = 64 - TAG_LSB;

    state_e             state_q, state_d;
    req_t               req_q, req_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic               done_d, mem_req_d, mem_we_d;
    logic [63:0]        rdata_d, mem_addr_d, mem_wdata_d;

    logic [OFF_W-1:0]   off_c;
    logic [IDX_W-1:0]   idx_c;
    logic [TAG_W-1:0]   tag_c;
    logic               rd_valid_c, hit_c;
    logic [TAG_W-1:0]   rd_tag_c;
    logic [63:0]        rd_data_c;
    logic               wr_en_c, fill_en_c;
    logic [OFF_W-1:0]   wr_off_c;
    logic [63:0]        wr_data_c;
    logic               unused_addr_lsb;

    assign unused_addr_lsb = ^dcache_addr[2:0];

    assign off_c = req_q.addr[LINE_LSB-1:3];
    assign idx_c = req_q.addr[TAG_LSB-1:LINE_LSB];
    assign tag_c = req_q.addr[63:TAG_LSB];
    assign hit_c = rd_valid_c && (rd_tag_c == tag_c);

    dcache_array #(
        .SETS  (SETS),
        .WORDS (WORDS),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (idx_c),
        .rd_offset  (off_c),
        .rd_valid_c (rd_valid_c),
        .rd_tag_c   (rd_tag_c),
        .rd_data_c  (rd_data_c),
        .wr_en      (wr_en_c),
        .wr_index   (idx_c),
        .wr_offset  (wr_off_c),
        .wr_data    (wr_data_c),
        .fill_en    (fill_en_c),
        .fill_tag   (tag_c)
    );

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            beat_q       <= '0;
            dcache_done  <= 1'b0;
            dcache_rdata <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            beat_q       <= beat_d;
            dcache_done  <= done_d;
            dcache_rdata <= rdata_d;
            mem_req      <= mem_req_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
        end
    end

    // Next-state, next-output and array write control
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        beat_d      = beat_q;
        done_d      = 1'b0;
        rdata_d     = dcache_rdata;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        wr_en_c     = 1'b0;
        fill_en_c   = 1'b0;
        wr_off_c    = off_c;
        wr_data_c   = req_q.wdata;

        case (state_q)
            ST_IDLE: begin
                if (dcache_en) begin
                    req_d.addr  = {dcache_addr[63:3], 3'b000};
                    req_d.wren  = dcache_wren;
                    req_d.wdata = dcache_wdata;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!req_q.wren) begin
                    if (hit_c) begin
                        rdata_d = rd_data_c;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_q.addr[63:LINE_LSB], {LINE_LSB{1'b0}}};
                        beat_d     = '0;
                        state_d    = ST_REFILL;
                    end
                end else begin
                    // Store updates the line only on hit; always written through
                    wr_en_c     = hit_c;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = req_q.addr;
                    mem_wdata_d = req_q.wdata;
                    state_d     = ST_WTHRU;
                end
            end
            ST_REFILL: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                end
                if (mem_rvalid) begin
                    wr_en_c   = 1'b1;
                    wr_off_c  = beat_q;
                    wr_data_c = mem_rdata;
                    if (beat_q == off_c) begin
                        rdata_d = mem_rdata;
                    end
                    if (beat_q == OFF_W'(WORDS - 1)) begin
                        fill_en_c = 1'b1;
                        done_d    = 1'b1;
                        beat_d    = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        beat_d = beat_q + OFF_W'(1);
                    end
                end
            end
            ST_WTHRU: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    // Hit/miss counters, one tick per LOOKUP cycle for loads and stores
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit_c) begin
                stat_hits <= stat_hits + 32'd1;
            end else begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench with a behavioural cache/memory model and a memory responder.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    localparam int unsigned SETS  = 64;
    localparam int unsigned WORDS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        dcache_en, dcache_wren;
    logic [63:0] dcache_addr, dcache_wdata, dcache_rdata;
    logic        dcache_done;
    logic        mem_req, mem_we, mem_ack, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    dcache_ctrl #(.SETS(SETS), .WORDS(WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .dcache_en    (dcache_en),
        .dcache_wren  (dcache_wren),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_rdata (dcache_rdata),
        .dcache_done  (dcache_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        bit          miss;
        logic [63:0] rdata;
        int          issue_cyc;
        int          reads_before;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         exp_wr_q[$];
    logic [63:0] exp_rd_q[$];

    // Reference model: line presence per set, plus the memory image
    bit          ref_valid [SETS];
    logic [51:0] ref_tag   [SETS];
    logic [63:0] ref_mem   [logic [63:0]];
    int unsigned m_hits, m_misses;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_reads  = 0;
    int ack_cyc  = 0;
    int last_beat_cyc = 0;
    int abort_at = -1;
    bit aborted  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (a[63:6] == 58'h40) return 64'hA0 + 64'(a[5:3]);
        return {~a[31:0], a[31:0]};
    endfunction

    // Monitor: every done pulse pops and checks the oldest expected response
    exp_t me;
    always @(negedge clk) begin
        if (!reset && dcache_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                me = exp_q.pop_front();
                if (me.is_load) chk("load_rdata", dcache_rdata, me.rdata);
                chk("refill_count", 64'(n_reads - me.reads_before), 64'(me.miss));
                if (me.is_load && !me.miss) chk("hit_latency", 64'(cyc - me.issue_cyc), 64'd2);
                if (me.is_load && me.miss)  chk("miss_done_timing", 64'(cyc), 64'(last_beat_cyc + 1));
                if (!me.is_load)            chk("store_done_timing", 64'(cyc), 64'(ack_cyc + 1));
            end
        end
    end

    // Memory responder: checks requests, acks with random delay, streams refill beats
    initial begin : responder
        logic [63:0] line;
        wr_t         w;
        bit          drop_chk;
        bit          saw;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_req) begin
                if (mem_we) begin
                    if (exp_wr_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_mem_write: got addr %h expected none", mem_addr);
                    end else begin
                        w = exp_wr_q.pop_front();
                        chk("mem_waddr", mem_addr, w.addr);
                        chk("mem_wdata", mem_wdata, w.data);
                    end
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    chk("wr_req_held", 64'(mem_req), 64'd1);
                    mem_ack = 1'b1;
                    ack_cyc = cyc;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    chk("wr_req_drop", 64'(mem_req), 64'd0);
                end else begin
                    n_reads++;
                    if (exp_rd_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_mem_read: got addr %h expected none", mem_addr);
                    end else begin
                        chk("mem_raddr", mem_addr, exp_rd_q.pop_front());
                    end
                    line = {mem_addr[63:6], 6'b0};
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    mem_ack  = 1'b1;
                    ack_cyc  = cyc;
                    drop_chk = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        @(negedge clk);
                        mem_ack = 1'b0;
                        chk("rd_req_drop", 64'(mem_req), 64'd0);
                        drop_chk = 1'b1;
                    end
                    for (int k = 0; k < int'(WORDS); k++) begin
                        if (k == abort_at) begin
                            abort_at = -1;
                            aborted  = 1'b1;
                            saw      = 1'b0;
                            for (int t = 0; t < 50 && !(saw && !reset); t++) begin
                                @(negedge clk);
                                if (reset) saw = 1'b1;
                            end
                            drop_chk = 1'b1;
                        end
                        if (k > 0) repeat ($urandom_range(0, 1)) @(negedge clk);
                        mem_rvalid    = 1'b1;
                        mem_rdata     = mem_rd(line + 64'(8 * k));
                        last_beat_cyc = cyc;
                        @(negedge clk);
                        mem_ack    = 1'b0;
                        mem_rvalid = 1'b0;
                        if (!drop_chk) begin
                            chk("rd_req_drop", 64'(mem_req), 64'd0);
                            drop_chk = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done();
        int t;
        t = 0;
        while (!dcache_done && t < 300) begin
            dcache_en    = ($urandom_range(0, 3) == 0);
            dcache_wren  = 1'($urandom_range(0, 1));
            dcache_addr  = {$urandom(), $urandom()};
            dcache_wdata = {$urandom(), $urandom()};
            @(negedge clk);
            t++;
        end
        dcache_en = 1'b0;
        if (!dcache_done) begin
            n_checks++;
            $display("FAIL done_timeout: got no done expected done within 300 cycles");
            exp_q.delete();
        end
    endtask

    // Issue one request (called at a negedge), updating the reference model
    task automatic do_op(input bit wr, input logic [63:0] a, input logic [63:0] wd, input bit wt);
        exp_t        e;
        logic [63:0] wa;
        int          idx;
        logic [51:0] tg;
        bit          hit;
        wa  = {a[63:3], 3'b000};
        idx = int'(a[11:6]);
        tg  = a[63:12];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        if (hit) m_hits++; else m_misses++;
        e.is_load      = !wr;
        e.miss         = 1'b0;
        e.rdata        = '0;
        e.issue_cyc    = cyc;
        e.reads_before = n_reads;
        if (wr) begin
            exp_wr_q.push_back('{wa, wd});
            ref_mem[wa] = wd;
        end else begin
            e.rdata = mem_rd(wa);
            e.miss  = !hit;
            if (!hit) begin
                exp_rd_q.push_back({a[63:6], 6'b0});
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
        end
        exp_q.push_back(e);
        dcache_en    = 1'b1;
        dcache_wren  = wr;
        dcache_addr  = a;
        dcache_wdata = wd;
        @(negedge clk);
        dcache_en    = 1'b0;
        dcache_addr  = {$urandom(), $urandom()};
        dcache_wdata = {$urandom(), $urandom()};
        if (wt) wait_done();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [63:0] a;
        reset        = 1'b1;
        dcache_en    = 1'b0;
        dcache_wren  = 1'b0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        m_hits       = 0;
        m_misses     = 0;
        for (int i = 0; i < int'(SETS); i++) ref_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done",      64'(dcache_done), 64'd0);
        chk("rst_rdata",     dcache_rdata,     64'd0);
        chk("rst_mem_req",   64'(mem_req),     64'd0);
        chk("rst_mem_we",    64'(mem_we),      64'd0);
        chk("rst_mem_addr",  mem_addr,         64'd0);
        chk("rst_mem_wdata", mem_wdata,        64'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_stat_hits",   64'(stat_hits),   64'd0);
        chk("rst_stat_misses", 64'(stat_misses), 64'd0);
`endif

        // Cold load, reload hit, store hit then load
        do_op(1'b0, 64'h1008, '0, 1'b1);
        do_op(1'b0, 64'h1010, '0, 1'b1);
        do_op(1'b1, 64'h1010, 64'hDEAD, 1'b1);
        do_op(1'b0, 64'h1010, '0, 1'b1);
        // Store miss does not allocate
        do_op(1'b1, 64'h9000, 64'h1234_5678_9ABC_DEF0, 1'b1);
        do_op(1'b0, 64'h9000, '0, 1'b1);
        // Same-index conflict evicts
        do_op(1'b0, 64'h1000, '0, 1'b1);
        do_op(1'b0, 64'h1000 + 64'(SETS * 64), '0, 1'b1);
        do_op(1'b0, 64'h1000, '0, 1'b1);
        do_op(1'b0, 64'h2000, '0, 1'b1);

        // Reset in the middle of a refill, after beat 3
        aborted  = 1'b0;
        abort_at = 4;
        do_op(1'b0, 64'h1000, '0, 1'b0);
        for (int t = 0; t < 100 && !aborted; t++) @(negedge clk);
        chk("abort_reached", 64'(aborted), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < int'(SETS); i++) ref_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", 64'(mem_req),     64'd0);
        chk("abort_done",    64'(dcache_done), 64'd0);
`ifdef DCACHE_STATS_EN
        chk("abort_stat_hits",   64'(stat_hits),   64'd0);
        chk("abort_stat_misses", 64'(stat_misses), 64'd0);
`endif
        repeat (12) @(negedge clk);
        do_op(1'b0, 64'h1000, '0, 1'b1);
        do_op(1'b0, 64'h2000, '0, 1'b1);

        // Randomised mix over a few sets and tags
        for (int i = 0; i < 300; i++) begin
            a        = '0;
            a[13:12] = 2'($urandom_range(0, 3));
            a[7:6]   = 2'($urandom_range(0, 3));
            a[5:3]   = 3'($urandom_range(0, 7));
            a[2:0]   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a[63:48] = 16'($urandom_range(1, 3));
            do_op(($urandom_range(0, 2) == 0), a, {$urandom(), $urandom()}, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("exp_q_drained",  64'(exp_q.size()),    64'd0);
        chk("wr_q_drained",   64'(exp_wr_q.size()), 64'd0);
        chk("rd_q_drained",   64'(exp_rd_q.size()), 64'd0);
`ifdef DCACHE_STATS_EN
        chk("stat_hits",   64'(stat_hits),   64'(m_hits));
        chk("stat_misses", 64'(stat_misses), 64'(m_misses));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Data-cache responder serving the memory stage's `dcache_*` request interface. It accepts one single-cycle request pulse at a time, and answers reads from a direct-mapped, write-through array. Read misses are refilled as a line burst from the memory port, and every store is written through to memory. It sits between the memory pipeline stage and the memory/bus arbiter.

## Interface
- `SETS`, 64: number of lines; power of two.
- `WORDS`, 8: 64-bit words per line; power of two; also the refill burst length.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `dcache_en` in 1: request pulse; sampled only in IDLE.
- `dcache_wren` in 1: 1 = store, 0 = load; sampled with `dcache_en`.
- `dcache_addr` in 64: byte address; bits [2:0] ignored (8-byte words).
- `dcache_wdata` in 64: store data; sampled with `dcache_en`.
- `dcache_rdata` out 64: load data; valid only while `dcache_done`=1.
- `dcache_done` out 1: one-cycle completion pulse, for loads and stores.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 1: 1 = single-word write, 0 = line read.
- `mem_addr` out 64: word address for writes; line-aligned address for reads.
- `mem_wdata` out 64: write data.
- `mem_ack` in 1: request accepted; one cycle.
- `mem_rvalid` in 1: refill beat valid.
- `mem_rdata` in 64: refill beat data; beats arrive in ascending word order.

## Operation
- Address split:
  - offset = addr[2+log2(WORDS):3]
  - index = next log2(SETS) bits
  - tag = addr[63:3+log2(WORDS)+log2(SETS)]
- FSM states IDLE, LOOKUP, REFILL, WTHRU.
- IDLE:
  - On `dcache_en`, latch addr, wren and wdata, then go to LOOKUP.
  - `dcache_en` in any other state is ignored. The requester keeps at most one request outstanding.
- LOOKUP: hit = valid[index] && tag match.
  - Load hit: register the word into `dcache_rdata`, pulse done, go to IDLE.
  - Load miss: assert `mem_req`, `mem_we`=0, `mem_addr`=line base; go to REFILL.
  - Store, hit or miss: if hit, update the word in the array (no allocate on miss). Assert `mem_req`, `mem_we`=1, `mem_addr`={addr[63:3],3'b0}, `mem_wdata`; go to WTHRU.
- REFILL:
  - Drop `mem_req` after `mem_ack`.
  - Each `mem_rvalid` writes beat k into word k, with a 3-bit beat counter for WORDS=8.
  - Beat k == offset is also captured into `dcache_rdata`.
  - On beat WORDS-1, set valid and tag, pulse done, go to IDLE.
- WTHRU: on `mem_ack`, drop `mem_req`, pulse done, go to IDLE.
- `mem_rvalid` outside REFILL is dropped.
- Reset values:
  - All outputs 0.
  - All valid bits cleared, state IDLE, beat counter 0.
  - Reset mid-refill abandons the line; the line stays invalid and no done is issued.

## Timing
- Loads:
  - `dcache_en` sampled at edge E0 → LOOKUP during cycle 1 → load-hit done high in cycle 2 (latency 2).
  - Load miss: done in the cycle after the last `mem_rvalid` beat.
- Stores: done in the cycle after `mem_ack`.
- `dcache_done` is high exactly one cycle, and the FSM is already in IDLE in that cycle. A new `dcache_en` in the done cycle is accepted.
- `mem_ack` and the first `mem_rvalid` may arrive in the same cycle; both are honoured.
- Array write on a store hit occurs at the LOOKUP edge. A load to the same word issued right after that store's done returns the new data.

## Configuration
- `DCACHE_STATS_EN`: when defined, adds outputs `stat_hits` and `stat_misses` (32 bits each, wrapping).
  - Counters reset to 0.
  - Each counter increments once per LOOKUP, loads and stores both counted.
- Without the macro, neither the ports nor the counters exist, and behaviour is otherwise identical.

## Structure
- Package `dcache_pkg` holds:
  - the FSM state enum;
  - geometry localparams: offset, index and tag widths derived from the defaults;
  - the latched-request struct (addr, wren, wdata).
- Sub-module `dcache_array`:
  - valid, tag and data storage, `SETS`×`WORDS`×64;
  - combinational read by index/offset;
  - synchronous word write and line-valid/tag write;
  - valid-clear on `reset`.

## Test plan
- Cold load 0x1008:
  - mem_req with mem_addr=0x1000, then 8 beats of data = 0xA0+k.
  - `dcache_done` with rdata=0xA1 one cycle after beat 7.
- Reload of 0x1010 after the cold fill: no `mem_req`; done 2 cycles after en with rdata=0xA2.
- Store hit: store 0xDEAD to 0x1010 gives mem write 0x1010/0xDEAD and done after `mem_ack`. A following load of 0x1010 hits and returns 0xDEAD.
- Store miss to 0x9000: mem write issued. A following load of 0x9000 misses and refills; no allocation on the store.
- Conflict: load 0x1000, then load 0x1000+SETS×64 (same index) refills and evicts. A third load of 0x1000 misses again.
- Reset during REFILL after beat 3:
  - no done is issued, the remaining beats are dropped;
  - the next load of 0x1000 misses;
  - with `DCACHE_STATS_EN`, the counters read 0.
